// File: rtl/regalu_fwd.sv
// regalu_fwd: register file feeding a two-stage ALU pipeline (X, M) with
// writeback at the end of M and full operand forwarding from X and M.
//
// Parameters:
//   DW       data/register width (>= 8, power of two)
//   NREG     number of registers (power of two, >= 2)
//   ZERO_REG 1 = register 0 reads as zero and is never written/forwarded
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   hold             freeze the whole pipeline for this cycle
//   in_valid         an instruction is presented this cycle
//   RR1, RR2, WR     source A, source B and destination register numbers
//   INop             ALU operation (ADD SUB AND OR XOR SLT SLL SRL)
//   imm_sel, imm     select immediate instead of RD2 as operand B
//   RD1, RD2         forwarded operands (combinational, RD2 before imm mux)
//   WD, wb_wr        M-stage result and destination (writeback data)
//   wb_valid         M stage holds a valid instruction
//   wb_ovf           signed overflow of the M-stage ADD/SUB
module regalu_fwd #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic                    in_valid,
  input  logic [$clog2(NREG)-1:0] RR1,
  input  logic [$clog2(NREG)-1:0] RR2,
  input  logic [$clog2(NREG)-1:0] WR,
  input  logic [2:0]              INop,
  input  logic                    imm_sel,
  input  logic [DW-1:0]           imm,
  output logic [DW-1:0]           RD1,
  output logic [DW-1:0]           RD2,
  output logic [DW-1:0]           WD,
  output logic [$clog2(NREG)-1:0] wb_wr,
  output logic                    wb_valid,
  output logic                    wb_ovf
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DW);
  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_t;

  logic [DW-1:0] rf [NREG];

  // X stage
  logic          x_valid;
  logic [DW-1:0] x_a;
  logic [DW-1:0] x_b;
  alu_op_t       x_op;
  logic [AW-1:0] x_wr;

  // M stage
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_wr;
  logic          m_ovf;

  logic [DW-1:0] alu_y;
  logic          alu_ovf;
  logic          wb_we;
  logic          x_fwd_ok;
  logic          m_fwd_ok;

  // ALU on the X-stage operands
  always_comb begin
    alu_y   = '0;
    alu_ovf = 1'b0;
    unique case (x_op)
      OP_ADD: begin
        alu_y   = x_a + x_b;
        alu_ovf = (x_a[DW-1] == x_b[DW-1]) && (alu_y[DW-1] != x_a[DW-1]);
      end
      OP_SUB: begin
        alu_y   = x_a - x_b;
        alu_ovf = (x_a[DW-1] != x_b[DW-1]) && (alu_y[DW-1] != x_a[DW-1]);
      end
      OP_AND: alu_y = x_a & x_b;
      OP_OR:  alu_y = x_a | x_b;
      OP_XOR: alu_y = x_a ^ x_b;
      OP_SLT: alu_y = {{(DW-1){1'b0}}, ($signed(x_a) < $signed(x_b))};
      OP_SLL: alu_y = x_a << x_b[SW-1:0];
      OP_SRL: alu_y = x_a >> x_b[SW-1:0];
      default: alu_y = '0;
    endcase
  end

  // A stage may forward only if it holds a real instruction that targets a
  // writable register; the hardwired r0 never supplies data.
  always_comb begin
    x_fwd_ok = x_valid && !(ZR && (x_wr == '0));
    m_fwd_ok = m_valid && !(ZR && (m_wr == '0));
    wb_we    = m_fwd_ok;
  end

  // Operand forwarding, youngest producer first
  always_comb begin
    RD1 = rf[RR1];
    if (ZR && (RR1 == '0))             RD1 = '0;
    else if (x_fwd_ok && (x_wr == RR1)) RD1 = alu_y;
    else if (m_fwd_ok && (m_wr == RR1)) RD1 = m_data;

    RD2 = rf[RR2];
    if (ZR && (RR2 == '0))             RD2 = '0;
    else if (x_fwd_ok && (x_wr == RR2)) RD2 = alu_y;
    else if (m_fwd_ok && (m_wr == RR2)) RD2 = m_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      x_valid <= 1'b0;
      x_a     <= '0;
      x_b     <= '0;
      x_op    <= OP_ADD;
      x_wr    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_wr    <= '0;
      m_ovf   <= 1'b0;
    end else if (!hold) begin
      if (wb_we) rf[m_wr] <= m_data;
      x_valid <= in_valid;
      x_a     <= RD1;
      x_b     <= imm_sel ? imm : RD2;
      x_op    <= alu_op_t'(INop);
      x_wr    <= WR;
      m_valid <= x_valid;
      m_data  <= alu_y;
      m_wr    <= x_wr;
      m_ovf   <= alu_ovf;
    end
  end

  assign WD       = m_data;
  assign wb_wr    = m_wr;
  assign wb_valid = m_valid;
  assign wb_ovf   = m_ovf;

endmodule

// File: tb/tb_regalu_fwd.sv
// tb_regalu_fwd: directed, self-checking bench for regalu_fwd.
// Three instances share one stimulus stream:
//   u0  DW=32 NREG=32 ZERO_REG=1 (main checks)
//   u1  DW=32 NREG=32 ZERO_REG=0 (r0 as an ordinary register)
//   u2  DW=16 NREG=8  ZERO_REG=1 (register numbers/immediates truncated)
module tb_regalu_fwd;

  logic        clk = 1'b0;
  logic        reset, hold, in_valid, imm_sel;
  logic [4:0]  rr1, rr2, wr;
  logic [2:0]  inop;
  logic [31:0] imm;

  logic [31:0] rd1_0, rd2_0, wd_0;
  logic [4:0]  wbwr_0;
  logic        wbv_0, ovf_0;
  logic [31:0] rd1_1, rd2_1, wd_1;
  logic [4:0]  wbwr_1;
  logic        wbv_1, ovf_1;
  logic [15:0] rd1_2, rd2_2, wd_2;
  logic [2:0]  wbwr_2;
  logic        wbv_2, ovf_2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regalu_fwd #(.DW(32), .NREG(32), .ZERO_REG(1)) u0 (
    .clk(clk), .reset(reset), .hold(hold), .in_valid(in_valid),
    .RR1(rr1), .RR2(rr2), .WR(wr), .INop(inop), .imm_sel(imm_sel), .imm(imm),
    .RD1(rd1_0), .RD2(rd2_0), .WD(wd_0), .wb_wr(wbwr_0),
    .wb_valid(wbv_0), .wb_ovf(ovf_0)
  );

  regalu_fwd #(.DW(32), .NREG(32), .ZERO_REG(0)) u1 (
    .clk(clk), .reset(reset), .hold(hold), .in_valid(in_valid),
    .RR1(rr1), .RR2(rr2), .WR(wr), .INop(inop), .imm_sel(imm_sel), .imm(imm),
    .RD1(rd1_1), .RD2(rd2_1), .WD(wd_1), .wb_wr(wbwr_1),
    .wb_valid(wbv_1), .wb_ovf(ovf_1)
  );

  regalu_fwd #(.DW(16), .NREG(8), .ZERO_REG(1)) u2 (
    .clk(clk), .reset(reset), .hold(hold), .in_valid(in_valid),
    .RR1(rr1[2:0]), .RR2(rr2[2:0]), .WR(wr[2:0]), .INop(inop),
    .imm_sel(imm_sel), .imm(imm[15:0]),
    .RD1(rd1_2), .RD2(rd2_2), .WD(wd_2), .wb_wr(wbwr_2),
    .wb_valid(wbv_2), .wb_ovf(ovf_2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [2:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d,
                       input logic isel, input logic [31:0] im);
    in_valid = v;
    inop     = op;
    rr1      = a;
    rr2      = b;
    wr       = d;
    imm_sel  = isel;
    imm      = im;
  endtask

  // bubble with junk fields: must neither forward nor write r1
  task automatic bubble();
    issue(1'b0, 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd99);
  endtask

  task automatic peek(input logic [4:0] a, input logic [4:0] b);
    bubble();
    rr1 = a;
    rr2 = b;
    #1;
  endtask

  // arithmetic edge vectors: op, rs1, imm, dest, expected WD, expected ovf
  logic [2:0]  av_op  [10];
  logic [4:0]  av_rs  [10];
  logic [31:0] av_imm [10];
  logic [4:0]  av_rd  [10];
  logic [31:0] av_wd  [10];
  logic        av_ovf [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    bubble();
    tick();
    tick();
    reset = 1'b0;

    // 1. reset state
    check("rst_wd", wd_0, 0);
    check("rst_wbv", wbv_0, 0);
    check("rst_ovf", ovf_0, 0);
    check("rst_wbv16", wbv_2, 0);
    for (int r = 0; r < 32; r++) begin
      peek(5'(r), 5'(31 - r));
      check($sformatf("rst_rd1_r%0d", r), rd1_0, 0);
      check($sformatf("rst_rd2_r%0d", r), rd2_0, 0);
      check($sformatf("rst_z0_r%0d", r), rd1_1, 0);
      check($sformatf("rst_16_r%0d", r), rd1_2, 0);
      tick();
    end

    // 2. back-to-back forwarding
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5);  tick();
    issue(1'b1, 3'd0, 5'd1, 5'd0, 5'd2, 1'b1, 32'd3);  tick();
    check("b2b_wd1", wd_0, 5);  check("b2b_v1", wbv_0, 1); check("b2b16_wd1", wd_2, 5);
    issue(1'b1, 3'd1, 5'd2, 5'd1, 5'd3, 1'b0, 32'd77); tick();
    check("b2b_wd2", wd_0, 8);  check("b2b_v2", wbv_0, 1); check("b2b16_wd2", wd_2, 8);
    issue(1'b1, 3'd2, 5'd3, 5'd2, 5'd4, 1'b0, 32'd77); tick();
    check("b2b_wd3", wd_0, 3);  check("b2b_v3", wbv_0, 1); check("b2b16_wd3", wd_2, 3);
    bubble(); tick();
    check("b2b_wd4", wd_0, 0);  check("b2b_v4", wbv_0, 1); check("b2b16_wd4", wd_2, 0);
    tick(); tick();
    check("bubble_v", wbv_0, 0);
    peek(5'd1, 5'd2); check("rf_r1", rd1_0, 5); check("rf_r2", rd2_0, 8);
    check("rf16_r1", rd1_2, 5);
    peek(5'd3, 5'd4); check("rf_r3", rd1_0, 3); check("rf_r4", rd2_0, 0);
    tick();

    // 3. zero register (u0 hardwired, u1 ordinary)
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7); tick();
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd0); tick();
    check("z_wd7", wd_0, 7);   check("z_v7", wbv_0, 1); check("z_wr0", wbwr_0, 0);
    check("nz_wd7", wd_1, 7);
    bubble(); tick();
    check("z_wd_r5", wd_0, 0); check("nz_wd_r5", wd_1, 7);
    tick(); tick();
    peek(5'd0, 5'd5);
    check("z_r0", rd1_0, 0);  check("z_r5", rd2_0, 0);
    check("nz_r0", rd1_1, 7); check("nz_r5", rd2_1, 7);
    tick();

    // 4. hold with r9 in M and r6 in X
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd9, 1'b1, 32'd11); tick();
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd6, 1'b1, 32'd9);  tick();
    hold = 1'b1;
    issue(1'b1, 3'd0, 5'd6, 5'd9, 5'd6, 1'b1, 32'd100);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold_wd_%0d", i), wd_0, 11);
      check($sformatf("hold_v_%0d", i), wbv_0, 1);
      check($sformatf("hold_wr_%0d", i), wbwr_0, 9);
      check($sformatf("hold_rd1_%0d", i), rd1_0, 9);
      check($sformatf("hold_rd2_%0d", i), rd2_0, 11);
      tick();
    end
    hold = 1'b0;
    issue(1'b1, 3'd0, 5'd6, 5'd0, 5'd10, 1'b1, 32'd1);
    #1;
    check("rel_rd1", rd1_0, 9);
    tick();
    check("rel_wd9", wd_0, 9); check("rel_wr6", wbwr_0, 6);
    bubble(); tick();
    check("rel_wd10", wd_0, 10);
    tick(); tick();
    peek(5'd6, 5'd9);  check("rel_r6", rd1_0, 9);  check("rel_r9", rd2_0, 11);
    peek(5'd10, 5'd6); check("rel_r10", rd1_0, 10);
    tick();

    // 5. arithmetic edges
    av_op = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd7, 3'd6, 3'd0};
    av_rs = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd11, 5'd12, 5'd13, 5'd12, 5'd14, 5'd15};
    av_imm = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1,
               32'd1, 32'd1, 32'd31, 32'd33, 32'h8000_0000};
    av_rd = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
    av_wd = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
              32'h7FFF_FFFF, 32'd1, 32'd1, 32'd2, 32'd0};
    av_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) issue(1'b1, av_op[k], av_rs[k], 5'd0, av_rd[k], 1'b1, av_imm[k]);
      else bubble();
      tick();
      if (k >= 1) begin
        check($sformatf("arith_wd_%0d", k - 1), wd_0, av_wd[k-1]);
        check($sformatf("arith_ovf_%0d", k - 1), ovf_0, av_ovf[k-1]);
      end
    end
    tick(); tick();

    // 6. reset mid-flight: r8 in M, r7 in X
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd8, 1'b1, 32'd2); tick();
    issue(1'b1, 3'd0, 5'd0, 5'd0, 5'd7, 1'b1, 32'd1); tick();
    check("mf_wd", wd_0, 2); check("mf_v", wbv_0, 1); check("mf16_v", wbv_2, 1);
    reset = 1'b1;
    bubble(); tick();
    reset = 1'b0;
    check("mf_rst_v", wbv_0, 0); check("mf_rst_wd", wd_0, 0);
    check("mf16_rst_v", wbv_2, 0); check("mf16_rst_wd", wd_2, 0);
    peek(5'd7, 5'd8);
    check("mf_r7", rd1_0, 0); check("mf_r8", rd2_0, 0); check("mf16_r7", rd1_2, 0);
    tick(); tick();
    peek(5'd7, 5'd1);
    check("mf_r7_late", rd1_0, 0); check("mf_r1_clr", rd2_0, 0);
    check("mf16_r1_clr", rd2_2, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regalu_fwd.md
Name: regalu_fwd

Overview:
Parametrised successor to the 2-stage register-file/ALU pipe: a register file plus a 2-stage ALU pipeline (X, M) with writeback at the end of M. Adds over the previous generation:
- configurable data width and register count
- per-instruction valid and immediate operand select
- full operand forwarding from X and M, so back-to-back dependent instructions need no stall
- global hold, optional hardwired-zero r0, signed-overflow flag
- synchronous reset

Parameters:
DW, 32, data/register width in bits (≥8, power of two)
NREG, 32, number of registers (power of two, ≥2); AW = $clog2(NREG) is derived, not a parameter
ZERO_REG, 1, 1 = register 0 reads as 0 and is never written or forwarded; 0 = ordinary register

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
hold  input  1  freeze whole pipeline this cycle
in_valid  input  1  instruction present this cycle
RR1  input  AW  source register A
RR2  input  AW  source register B
WR  input  AW  destination register
INop  input  3  ALU op
imm_sel  input  1  1 = operand B is imm instead of RD2
imm  input  DW  immediate operand
RD1  output  DW  forwarded operand A (combinational)
RD2  output  DW  forwarded operand B (combinational, before imm mux)
WD  output  DW  M-stage result / writeback data
wb_wr  output  AW  M-stage destination
wb_valid  output  1  M-stage holds a valid instruction
wb_ovf  output  1  signed overflow of M-stage ADD/SUB, else 0

Behaviour:
- Reset (synchronous, dominates hold):
  - all NREG registers = 0
  - X and M valid = 0
  - M data, wb_wr and wb_ovf = 0
  - Consequence after reset: WD = 0, wb_valid = 0, wb_ovf = 0.
- Issue, cycle t: RD1/RD2 formed combinationally. At the edge ending t (if !hold), X captures valid, a = RD1, b = imm_sel ? imm : RD2, INop, WR.
- X, cycle t+1: ALU computes from the X registers. At the edge, M captures valid, result, WR and ovf.
- M, cycle t+2: drives WD, wb_wr, wb_valid, wb_ovf. At the edge ending t+2, if wb_valid && !hold && !(ZERO_REG && wb_wr==0), the register file writes WD to wb_wr.
- Latency: issue to WD is 2 cycles; issue to architectural write is 3 edges.
- Forwarding for each of RD1/RD2, reading register r, first match wins:
  1. If ZERO_REG && r==0: result is 0.
  2. Else if X valid && X.WR==r: current X ALU output.
  3. Else if M valid && wb_wr==r: WD.
  4. Else: register file contents.
- Result: any in-order dependent sequence, including back-to-back, reads the youngest value.
- Hold:
  - no pipeline register, valid bit or register-file entry changes
  - inputs are ignored
  - outputs stay stable, combinationally consistent with the frozen state
  - releasing hold resumes with no lost or duplicated writes
- in_valid = 0: a bubble (X valid = 0) enters the pipeline; data fields may update but are don't-care. Bubbles never forward and never write.
- INop, with a = operand A and b = operand B:
  - 0 ADD: a+b, modulo 2^DW
  - 1 SUB: a−b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT: signed a<b gives 1, else 0; zero-extended to DW
  - 6 SLL: a << b[$clog2(DW)-1:0]
  - 7 SRL: logical a >> b[$clog2(DW)-1:0]
- ovf:
  - ADD: operands same sign and result sign differs
  - SUB: operands differ in sign and result sign differs from a
  - all other ops: 0
- ZERO_REG=1, WR=0: the instruction flows normally (wb_valid=1, WD = result) but does not write and does not forward.
- Same-cycle write and read of register r in the file: forwarding from M covers it; the file itself is write-on-edge.
- Reset mid-operation: in-flight X/M instructions are discarded, with no writeback on the reset edge.

Test Plan:
1. Reset 2 cycles, then sweep RR1/RR2 over all registers → RD1=RD2=0, WD=0, wb_valid=0, wb_ovf=0.
2. Back-to-back forwarding:
   - Stimulus, consecutive cycles: ADD r1=r0+imm 5; ADD r2=r1+imm 3; SUB r3=r2−r1 (imm_sel=0); AND r4=r3&r2.
   - Required: WD = 5, 8, 3, 0 on cycles t+2..t+5, each with wb_valid=1.
   - Afterwards: reading r1..r4 gives 5, 8, 3, 0.
3. Zero register, ZERO_REG=1:
   - ADD r0=r0+imm 7 → WD=7, wb_valid=1.
   - Then ADD r5=r0+imm 0 → WD=0; r0 still reads 0.
   - Repeat with ZERO_REG=0 → r5 gets 7.
4. Hold:
   - Issue ADD r6=r0+imm 9, then assert hold for 3 cycles while it is in X.
   - Required: WD, wb_valid and RD1/RD2 stable during hold.
   - After release: WD=9 appears 1 cycle later, r6=9 written exactly once, and the instruction issued after hold sees 9 via forwarding.
5. Arithmetic edges, DW=32:
   - 0x7FFFFFFF+1 → WD=0x80000000, wb_ovf=1.
   - 0x80000000−1 → 0x7FFFFFFF, wb_ovf=1.
   - SLT 0xFFFFFFFF,1 → 1.
   - SRL 0x80000000 by 31 → 1.
   - SLL 1 by 33 → 2 (shift count masked).
6. Reset mid-flight:
   - With ADD r7=imm 1 in X and ADD r8=imm 2 in M, assert reset for 1 cycle.
   - Required: wb_valid=0 the next cycle; r7 and r8 read 0.
   - Repeat at DW=16, NREG=8 to check parametrisation.
